// File: rtl/da_rom_loader.sv
// da_rom_loader: builds the 8x256 distributed-arithmetic partial-sum tables from 64 taps and streams them out
module da_rom_loader #(
    parameter int COEF_W = 16,
    parameter int CIN_W  = 20,
    parameter int NTAPS  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     COEF_WE,
    input  logic [5:0]               COEF_ADDR,
    input  logic signed [COEF_W-1:0] COEF_IN,
    input  logic                     start,
    input  logic                     CREADY,
    output logic [10:0]              CADDR,
    output logic signed [CIN_W-1:0]  CIN,
    output logic                     CLOAD,
    output logic                     busy,
    output logic                     done
);
    typedef enum logic {IDLE, LOAD} state_t;
    state_t r_state;
    logic signed [COEF_W-1:0] r_tap [NTAPS];
    logic [10:0] w_next_addr;
    logic signed [COEF_W-1:0] w_t;
    logic signed [CIN_W-1:0] w_sum;
    assign w_next_addr = CADDR + 11'd1;
    // Partial sum for the word after the current one, so CIN stays registered
    always_comb begin
        w_sum = '0;
        w_t = '0;
        for (int j = 0; j < 8; j++) begin
            w_t = r_tap[{w_next_addr[10:8], 3'(j)}];
            w_sum = w_sum + (w_next_addr[j] ? {{(CIN_W-COEF_W){w_t[COEF_W-1]}}, w_t} : '0);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            CADDR <= '0;
            CIN <= '0;
            CLOAD <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            for (int i = 0; i < NTAPS; i++) r_tap[i] <= '0;
        end else begin
            done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_state <= LOAD;
                    CADDR <= '0;
                    CIN <= '0;
                    CLOAD <= 1'b1;
                    busy <= 1'b1;
                end else if (COEF_WE) begin
                    r_tap[COEF_ADDR] <= COEF_IN;
                end
            end else if (CREADY) begin
                if (CADDR == 11'd2047) begin
                    r_state <= IDLE;
                    CLOAD <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    CADDR <= w_next_addr;
                    CIN <= w_sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_da_rom_loader.sv
// tb_da_rom_loader: directed vectors and stream scoreboard for da_rom_loader
module tb_da_rom_loader;
    logic clk = 1'b0;
    logic reset, COEF_WE, start, CREADY;
    logic [5:0] COEF_ADDR;
    logic signed [15:0] COEF_IN;
    logic [10:0] CADDR;
    logic signed [19:0] CIN;
    logic CLOAD, busy, done;

    da_rom_loader dut (
        .clk(clk), .reset(reset), .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR),
        .COEF_IN(COEF_IN), .start(start), .CREADY(CREADY), .CADDR(CADDR),
        .CIN(CIN), .CLOAD(CLOAD), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              name;
        logic [10:0]        addr;
        logic signed [19:0] exp;
    } vec_t;

    vec_t ramp_v[5];
    vec_t neg_v[3];
    int n_checks = 0;
    int n_fail = 0;
    int tb_tap[64];
    logic signed [19:0] cap[2048];

    task automatic ck();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_tap(input int t, input int v);
        COEF_WE = 1'b1;
        COEF_ADDR = 6'(t);
        COEF_IN = 16'(v);
        ck();
        COEF_WE = 1'b0;
        tb_tap[t] = v;
    endtask

    function automatic logic signed [19:0] model(input logic [10:0] a);
        int s = 0;
        for (int j = 0; j < 8; j++)
            if (a[j]) s += tb_tap[8 * int'(a[10:8]) + j];
        return 20'(s);
    endfunction

    task automatic check_model(input string nm);
        int e = 0;
        for (int a = 0; a < 2048; a++)
            if (cap[a] !== model(11'(a))) e++;
        check(nm, e, 0);
    endtask

    // inj: 0 plain, 1 tap write together with start, 2 write+start mid-stream, 3 reset at 0x300
    task automatic run(input bit bp, input int inj, output int done_c);
        int c = 1, beats = 0, oerr = 0, serr = 0;
        bit st = 1'b0;
        logic [10:0] pa = '0;
        logic signed [19:0] pc = '0;
        done_c = -1;
        for (int i = 0; i < 2048; i++) cap[i] = 20'h55555;
        start = 1'b1;
        if (inj == 1) begin
            COEF_WE = 1'b1;
            COEF_ADDR = 6'd1;
            COEF_IN = 16'sd999;
        end
        ck();
        start = 1'b0;
        COEF_WE = 1'b0;
        while (c < 12000) begin
            if (st && (CADDR !== pa || CIN !== pc || CLOAD !== 1'b1)) serr++;
            if (done) begin
                done_c = c;
                break;
            end
            if (inj == 3 && CLOAD && CADDR == 11'h300) begin
                reset = 1'b1;
                COEF_WE = 1'b0;
                start = 1'b0;
                ck();
                reset = 1'b0;
                check("rst_cload", 32'(CLOAD), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_done", 32'(done), 0);
                ck();
                check("rst_nodone", 32'(done), 0);
                check("rst_idle_cload", 32'(CLOAD), 0);
                return;
            end
            CREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            COEF_WE = 1'b0;
            start = 1'b0;
            if (inj == 2 && CLOAD && CADDR == 11'h010) begin
                COEF_WE = 1'b1;
                COEF_ADDR = 6'd0;
                COEF_IN = 16'sd100;
                start = 1'b1;
            end
            if (CLOAD && CREADY) begin
                if (CADDR !== 11'(beats)) oerr++;
                cap[CADDR] = CIN;
                beats++;
            end
            st = CLOAD && !CREADY;
            pa = CADDR;
            pc = CIN;
            ck();
            c++;
        end
        COEF_WE = 1'b0;
        start = 1'b0;
        if (done_c < 0) check("done_timeout", 0, 1);
        check("beats", beats, 2048);
        check("order", oerr, 0);
        check("stall_hold", serr, 0);
        check("busy_at_done", 32'(busy), 0);
        check("cload_at_done", 32'(CLOAD), 0);
        ck();
        check("done_pulse_width", 32'(done), 0);
    endtask

    initial begin
        int dc;
        ramp_v[0] = '{"ramp_0FF", 11'h0FF, 20'sd36};
        ramp_v[1] = '{"ramp_701", 11'h701, 20'sd57};
        ramp_v[2] = '{"ramp_705", 11'h705, 20'sd116};
        ramp_v[3] = '{"ramp_7FF", 11'h7FF, 20'sd484};
        ramp_v[4] = '{"ramp_100", 11'h100, 20'sd0};
        neg_v[0] = '{"neg_1FF", 11'h1FF, 20'shC0000};
        neg_v[1] = '{"neg_101", 11'h101, -20'sd32768};
        neg_v[2] = '{"neg_0FF", 11'h0FF, 20'sd0};
        reset = 1'b1;
        COEF_WE = 1'b0;
        COEF_ADDR = '0;
        COEF_IN = '0;
        start = 1'b0;
        CREADY = 1'b0;
        for (int t = 0; t < 64; t++) tb_tap[t] = 0;
        ck();
        ck();
        check("reset_cload", 32'(CLOAD), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_caddr", 32'(CADDR), 0);
        check("reset_cin", CIN, 0);
        reset = 1'b0;
        ck();

        run(1'b0, 0, dc);
        check("zero_done_cycle", dc, 2049);
        check_model("zero_table");

        for (int t = 0; t < 64; t++) set_tap(t, t + 1);
        run(1'b0, 0, dc);
        for (int i = 0; i < 5; i++) check(ramp_v[i].name, cap[ramp_v[i].addr], ramp_v[i].exp);

        run(1'b1, 1, dc);
        check_model("bp_table");

        run(1'b0, 2, dc);
        check("ign_tap0_addr001", cap[11'h001], 1);
        check("ign_tap0_addr011", cap[11'h011], 6);
        check_model("ign_table");
        set_tap(0, 100);
        run(1'b0, 0, dc);
        check("new_tap0_addr001", cap[11'h001], 100);
        check_model("new_tap_table");

        for (int t = 0; t < 64; t++) set_tap(t, (t >= 8 && t < 16) ? -32768 : 0);
        run(1'b0, 0, dc);
        for (int i = 0; i < 3; i++) check(neg_v[i].name, cap[neg_v[i].addr], neg_v[i].exp);

        run(1'b0, 3, dc);
        for (int t = 0; t < 64; t++) tb_tap[t] = 0;
        run(1'b0, 0, dc);
        check("post_reset_done_cycle", dc, 2049);
        check_model("post_reset_zero_table");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
